// File: rtl/button_pkg.sv
// Shared types and width helpers for the multi-channel button pulse generator.
package button_pkg;

  typedef enum logic [2:0] {IDLE, FIRE, DELAY, RFIRE, RWAIT, HOLD} btn_state_t;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 1000;
  localparam int DEF_REPEAT_DLY   = 5000;
  localparam int DEF_REPEAT_PER   = 1000;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce, press/repeat FSM and repeat timer.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic repeat_en,
  output logic shot,
  output logic level
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYC);
  localparam int TM_W = cnt_width(max2(REPEAT_DLY, REPEAT_PER));
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TM_W-1:0] DLY_LAST = TM_W'(REPEAT_DLY - 2);
  localparam logic [TM_W-1:0] PER_LAST = TM_W'(REPEAT_PER - 2);
  localparam logic [TM_W-1:0] TM_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic [DB_W-1:0]        db_cnt;
  logic [TM_W-1:0]        timer;
  logic                   sync, stable, stable_q, armed, rise;
  btn_state_t             state_q, state_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // fill_q marks when the chain holds only post-reset samples of the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt   <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      stable_q <= stable;
      if (sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      // A button held through reset must be seen released before it may fire.
      if (fill_q[SYNC_STAGES-1] && !sync && !stable)
        armed <= 1'b1;
    end
  end

  assign rise = stable & ~stable_q & armed;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else begin
      case (state_q)
        FIRE, RFIRE:  timer <= '0;
        DELAY, RWAIT: if (timer != TM_MAX) timer <= timer + 1'b1;
        default:      timer <= timer;
      endcase
    end
  end

  // Release outranks repeat disable, which outranks timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (rise) state_d = FIRE;
      FIRE:  if (!stable)         state_d = IDLE;
             else if (repeat_en)  state_d = DELAY;
             else                 state_d = HOLD;
      DELAY: if (!stable)               state_d = IDLE;
             else if (!repeat_en)       state_d = HOLD;
             else if (timer == DLY_LAST) state_d = RFIRE;
      RFIRE: if (!stable)         state_d = IDLE;
             else if (!repeat_en) state_d = HOLD;
             else                 state_d = RWAIT;
      RWAIT: if (!stable)               state_d = IDLE;
             else if (!repeat_en)       state_d = HOLD;
             else if (timer == PER_LAST) state_d = RFIRE;
      HOLD:  if (!stable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shot  = (state_q == FIRE) || (state_q == RFIRE);
    level = stable;
  end

endmodule

// File: rtl/button_pulse_gen.sv
// N_CH independent debounced button channels producing one-cycle press/repeat pulses.
module button_pulse_gen
  import button_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] Button,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] ButtonShot,
  output logic [N_CH-1:0] ButtonLevel
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    button_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .button    (Button[gi]),
      .repeat_en (repeat_en[gi]),
      .shot      (ButtonShot[gi]),
      .level     (ButtonLevel[gi])
    );
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench: stimulus queues expected pulse cycles, a negedge monitor pops and compares.
module tb_button_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Button = '0;
  logic [1:0] repeat_en = '0;
  logic [1:0] ButtonShot, ButtonLevel;

  int cyc = 0;
  int checks = 0, errors = 0;
  int q0[$], q1[$];
  int t0, t1, e_mon;

  button_pulse_gen #(
    .N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .REPEAT_DLY(10), .REPEAT_PER(5)
  ) dut (
    .clk(clk), .reset(reset), .Button(Button), .repeat_en(repeat_en),
    .ButtonShot(ButtonShot), .ButtonLevel(ButtonLevel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic push(input int ch, input int t);
    if (ch == 0) q0.push_back(t);
    else         q1.push_back(t);
  endtask

  task automatic mon(input int ch);
    if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse_ch%0d: pulse at cycle %0d, none expected", ch, cyc);
    end else begin
      e_mon = (ch == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("pulse_cycle_ch%0d", ch), cyc, e_mon);
    end
  endtask

  always @(negedge clk) begin
    if (ButtonShot[0]) mon(0);
    if (ButtonShot[1]) mon(1);
  end

  task automatic check_drained(input string name);
    check({name, "_missing_ch0"}, q0.size(), 0);
    check({name, "_missing_ch1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("reset_shot", ButtonShot, 0);
    check("reset_level", ButtonLevel, 0);
    reset = 1'b0;
    tick(5);

    // Reset mid-hold, then release reset with the button still held
    t0 = cyc; Button[0] = 1'b1; push(0, t0 + 7);
    wait_to(t0 + 20); reset = 1'b1;
    tick(1);
    check("midreset_level", ButtonLevel, 0);
    check("midreset_shot", ButtonShot, 0);
    wait_to(t0 + 23); reset = 1'b0;
    wait_to(t0 + 60);
    check("held_after_reset_level", ButtonLevel[0], 1);
    check_drained("held_after_reset");
    Button[0] = 1'b0;
    wait_to(t0 + 75);
    check("released_level", ButtonLevel[0], 0);
    t1 = cyc; Button[0] = 1'b1; push(0, t1 + 7);
    wait_to(t1 + 15); Button[0] = 1'b0;
    wait_to(t1 + 30);
    check_drained("repress_after_reset");

    // Clean single press, no repeat: level at 6, pulse at 7, release latency 6
    t0 = cyc; Button[0] = 1'b1; push(0, t0 + 7);
    wait_to(t0 + 5);
    check("press_level_c5", ButtonLevel[0], 0);
    tick(1);
    check("press_level_c6", ButtonLevel[0], 1);
    wait_to(t0 + 40); Button[0] = 1'b0;
    wait_to(t0 + 45);
    check("release_level_c5", ButtonLevel[0], 1);
    tick(1);
    check("release_level_c6", ButtonLevel[0], 0);
    wait_to(t0 + 60);
    check_drained("single_press");

    // Short glitches and a bounce train: nothing accepted
    for (int w = 1; w <= 3; w++) begin
      Button[0] = 1'b1; tick(w);
      Button[0] = 1'b0; tick(6);
      check($sformatf("glitch%0d_level", w), ButtonLevel[0], 0);
    end
    for (int i = 0; i < 20; i++) begin
      Button[0] = (i < 16) && ((i % 4) != 3);
      tick(1);
      check("bounce_level", ButtonLevel[0], 0);
    end
    Button[0] = 1'b0;
    tick(10);
    check("bounce_end_level", ButtonLevel[0], 0);
    check_drained("bounce");

    // Ch1 held 40 cycles with repeat; release coincides with timer expiry
    repeat_en[1] = 1'b1;
    t0 = cyc; Button[1] = 1'b1;
    push(1, t0 + 7); push(1, t0 + 17); push(1, t0 + 22); push(1, t0 + 27);
    push(1, t0 + 32); push(1, t0 + 37); push(1, t0 + 42);
    wait_to(t0 + 40); Button[1] = 1'b0;
    wait_to(t0 + 60);
    check_drained("repeat_hold");

    // Repeat dropped at 20, raised at 30: stays in HOLD until the next press
    t0 = cyc; Button[1] = 1'b1; push(1, t0 + 7); push(1, t0 + 17);
    wait_to(t0 + 20); repeat_en[1] = 1'b0;
    wait_to(t0 + 30); repeat_en[1] = 1'b1;
    wait_to(t0 + 60); Button[1] = 1'b0;
    wait_to(t0 + 75);
    check_drained("repeat_drop");
    t1 = cyc; Button[1] = 1'b1; push(1, t1 + 7); push(1, t1 + 17);
    wait_to(t1 + 12); Button[1] = 1'b0;
    wait_to(t1 + 35);
    check_drained("repeat_repress");

    // Both channels pressed together, only ch0 repeats
    repeat_en = 2'b01;
    t0 = cyc; Button = 2'b11;
    push(0, t0 + 7); push(0, t0 + 17); push(0, t0 + 22); push(0, t0 + 27); push(0, t0 + 32);
    push(1, t0 + 7);
    wait_to(t0 + 30); Button = 2'b00;
    wait_to(t0 + 50);
    check("both_level", ButtonLevel, 0);
    check_drained("both");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
